// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter for the signed 8-bit Booth product.
// Converts |product| to three BCD digits plus sign with double dabble, one bit per clock.
module product_bcd_converter (
    input  logic       clk,
    input  logic       rstEx,
    input  logic       start,
    input  logic [7:0] product,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       negative,
    output logic       busy,
    output logic       valid
);

    // state | meaning
    // IDLE  | waiting for start; accepts start even during the valid pulse
    // CONV  | eight add-3/shift iterations, one per clock
    // DONE  | copy scratch to output digits and raise valid
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [11:0] scratch_q, scratch_d;
    logic [7:0]  mag_q, mag_d;
    logic        neg_q, neg_d;
    logic [3:0]  hund_q, hund_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;
    logic        negative_q, negative_d;
    logic        valid_q, valid_d;

    logic [11:0] adj;
    logic [19:0] shifted;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

    always_comb begin
        adj     = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};
        shifted = {adj[10:0], mag_q, 1'b0};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        scratch_d  = scratch_q;
        mag_d      = mag_q;
        neg_d      = neg_q;
        hund_d     = hund_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        negative_d = negative_q;
        valid_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // -128 negates to 0x80, which is the correct unsigned magnitude
                    mag_d     = product[7] ? (~product + 8'd1) : product;
                    neg_d     = product[7];
                    scratch_d = 12'd0;
                    cnt_d     = 4'd0;
                    state_d   = CONV;
                end
            end
            CONV: begin
                scratch_d = shifted[19:8];
                mag_d     = shifted[7:0];
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                hund_d     = scratch_q[11:8];
                tens_d     = scratch_q[7:4];
                ones_d     = scratch_q[3:0];
                negative_d = neg_q;
                valid_d    = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstEx) begin
        if (!rstEx) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            scratch_q  <= 12'd0;
            mag_q      <= 8'd0;
            neg_q      <= 1'b0;
            hund_q     <= 4'd0;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
            negative_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            scratch_q  <= scratch_d;
            mag_q      <= mag_d;
            neg_q      <= neg_d;
            hund_q     <= hund_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            negative_q <= negative_d;
            valid_q    <= valid_d;
        end
    end

    // The valid cycle still counts as busy, although the FSM is already back in IDLE
    assign busy     = (state_q != IDLE) || valid_q;
    assign valid    = valid_q;
    assign hundreds = hund_q;
    assign tens     = tens_q;
    assign ones     = ones_q;
    assign negative = negative_q;

endmodule
